// File: rtl/dcc_scheduler_if.sv
// Host-write and encoder-offer bundle for dcc_scheduler.
// master: host/encoder side; slave: scheduler side.
interface dcc_scheduler_if;
  logic       wr_en;
  logic       clr_en;
  logic [1:0] wr_slot;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [7:0] pkt_addr;
  logic [7:0] pkt_data;
  logic [7:0] pkt_err;
  logic [2:0] pkt_slot;

  modport master (
    output wr_en, clr_en, wr_slot,
    output wr_addr, wr_data, pkt_ready,
    input  pkt_valid, pkt_addr, pkt_data,
    input  pkt_err, pkt_slot
  );

  modport slave (
    input  wr_en, clr_en, wr_slot,
    input  wr_addr, wr_data, pkt_ready,
    output pkt_valid, pkt_addr, pkt_data,
    output pkt_err, pkt_slot
  );
endinterface

// File: rtl/dcc_scheduler.sv
// DCC packet scheduler: 4 command slots, urgent/refresh round-robin, idle fill.
// Ports: clk, reset (sync, active-high), bus (dcc_scheduler_if.slave),
// pkt_count[15:0] only when DCC_SCHED_COUNT_EN is defined.
module dcc_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int REPEAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  dcc_scheduler_if.slave    bus
`ifdef DCC_SCHED_COUNT_EN
  ,
  output logic [15:0]       pkt_count
`endif
);

  localparam logic [0:0] ST_SELECT = 1'b0;
  localparam logic [0:0] ST_OFFER  = 1'b1;

  logic [0:0] state;

  logic [NUM_SLOTS-1:0] valid;
  logic [NUM_SLOTS-1:0] urgent;
  logic [7:0] addr [NUM_SLOTS];
  logic [7:0] data [NUM_SLOTS];
  logic [3:0] rep  [NUM_SLOTS];

  logic [1:0] ptr_u;
  logic [1:0] ptr_v;

  logic [7:0] out_addr;
  logic [7:0] out_data;
  logic [2:0] out_slot;

  // Offered slot was rewritten while its packet was pending,
  // so the acceptance must not consume a repeat of the new command.
  logic       hit;

  logic       u_any;
  logic [1:0] u_idx;
  logic       v_any;
  logic [1:0] v_idx;
  logic [1:0] ui;
  logic [1:0] vi;
  logic       accept;

  assign accept        = (state == ST_OFFER) && bus.pkt_ready;
  assign bus.pkt_valid = (state == ST_OFFER);
  assign bus.pkt_addr  = out_addr;
  assign bus.pkt_data  = out_data;
  assign bus.pkt_err   = out_addr ^ out_data;
  assign bus.pkt_slot  = out_slot;

  // Scan from the highest offset down so the nearest slot
  // after the pointer is the one left standing.
  always_comb begin
    u_any = 1'b0;
    u_idx = ptr_u;
    v_any = 1'b0;
    v_idx = ptr_v;
    ui    = 2'd0;
    vi    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      ui = ptr_u + 2'(i);
      vi = ptr_v + 2'(i);
      if (urgent[ui]) begin
        u_any = 1'b1;
        u_idx = ui;
      end
      if (valid[vi]) begin
        v_any = 1'b1;
        v_idx = vi;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_SELECT;
      ptr_u    <= 2'd0;
      ptr_v    <= 2'd0;
      out_addr <= 8'h00;
      out_data <= 8'h00;
      out_slot <= 3'b000;
      hit      <= 1'b0;
    end else begin
      unique case (state)
        ST_SELECT: begin
          state <= ST_OFFER;
          if (u_any) begin
            out_addr <= addr[u_idx];
            out_data <= data[u_idx];
            out_slot <= {1'b0, u_idx};
            ptr_u    <= u_idx + 2'd1;
            hit      <= bus.wr_en && (bus.wr_slot == u_idx);
          end else if (v_any) begin
            out_addr <= addr[v_idx];
            out_data <= data[v_idx];
            out_slot <= {1'b0, v_idx};
            ptr_v    <= v_idx + 2'd1;
            hit      <= bus.wr_en && (bus.wr_slot == v_idx);
          end else begin
            out_addr <= 8'hFF;
            out_data <= 8'h00;
            out_slot <= 3'b100;
            hit      <= 1'b0;
          end
        end
        ST_OFFER: begin
          if (bus.pkt_ready) begin
            state <= ST_SELECT;
          end
          if (bus.wr_en && (bus.wr_slot == out_slot[1:0])) begin
            hit <= 1'b1;
          end
        end
        default: state <= ST_SELECT;
      endcase
    end
  end

  // Host write beats clear, and both beat the acceptance update.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (reset) begin
        valid[i]  <= 1'b0;
        urgent[i] <= 1'b0;
        rep[i]    <= 4'd0;
      end else if (bus.wr_en && (bus.wr_slot == 2'(i))) begin
        valid[i]  <= 1'b1;
        urgent[i] <= 1'b1;
        addr[i]   <= bus.wr_addr;
        data[i]   <= bus.wr_data;
        rep[i]    <= 4'(REPEAT);
      end else if (bus.clr_en && (bus.wr_slot == 2'(i))) begin
        valid[i]  <= 1'b0;
        urgent[i] <= 1'b0;
      end else if (accept && !out_slot[2] && !hit &&
                   (out_slot[1:0] == 2'(i)) && urgent[i]) begin
        rep[i] <= rep[i] - 4'd1;
        if (rep[i] == 4'd1) begin
          urgent[i] <= 1'b0;
        end
      end
    end
  end

`ifdef DCC_SCHED_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count <= 16'd0;
    end else if (accept) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcc_scheduler.sv
// Randomized and directed bench for dcc_scheduler.
// Checks every cycle against a transaction-level slot/queue model.
module tb_dcc_scheduler;

  localparam int REP = 2;

  logic clk;
  logic reset;

  dcc_scheduler_if bus ();

`ifdef DCC_SCHED_COUNT_EN
  logic [15:0] pkt_count;
`endif

  dcc_scheduler #(
    .NUM_SLOTS(4),
    .REPEAT(REP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
`ifdef DCC_SCHED_COUNT_EN
    ,
    .pkt_count(pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] e;
    logic [2:0] s;
  } pkt_t;

  pkt_t sent[$];

  // Reference model: per-slot command table plus the packet in flight.
  bit         m_v [4];
  bit         m_u [4];
  logic [7:0] m_a [4];
  logic [7:0] m_d [4];
  int         m_r [4];
  int         m_pu;
  int         m_pv;
  bit         m_ph;
  int         m_ix;
  bit         m_dirty;
  logic [7:0] m_oa;
  logic [7:0] m_od;
  logic [2:0] m_os;
  int         m_cnt;

  function automatic int rr(input bit f[4], input int p);
    for (int k = 0; k < 4; k++) begin
      if (f[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input bit w, input bit c,
                            input int s, input logic [7:0] a,
                            input logic [7:0] d, input bit r,
                            input bit rs);
    int g;
    if (rs) begin
      for (int i = 0; i < 4; i++) begin
        m_v[i] = 0;
        m_u[i] = 0;
        m_r[i] = 0;
      end
      m_pu = 0;
      m_pv = 0;
      m_ph = 0;
      m_ix = -1;
      m_dirty = 0;
      m_oa = 8'h00;
      m_od = 8'h00;
      m_os = 3'b000;
      m_cnt = 0;
      return;
    end
    if (!m_ph) begin
      g = rr(m_u, m_pu);
      if (g >= 0) begin
        m_pu = (g + 1) % 4;
      end else begin
        g = rr(m_v, m_pv);
        if (g >= 0) m_pv = (g + 1) % 4;
      end
      if (g >= 0) begin
        m_oa = m_a[g];
        m_od = m_d[g];
        m_os = 3'(g);
        m_ix = g;
        m_dirty = w && (s == g);
      end else begin
        m_oa = 8'hFF;
        m_od = 8'h00;
        m_os = 3'b100;
        m_ix = -1;
        m_dirty = 0;
      end
      m_ph = 1;
    end else if (r) begin
      if (m_ix >= 0 && m_u[m_ix] && !m_dirty &&
          !(w && s == m_ix)) begin
        m_r[m_ix]--;
        if (m_r[m_ix] == 0) m_u[m_ix] = 0;
      end
      m_ph = 0;
      m_cnt++;
    end else if (m_ix >= 0 && w && s == m_ix) begin
      m_dirty = 1;
    end
    if (w) begin
      m_v[s] = 1;
      m_u[s] = 1;
      m_a[s] = a;
      m_d[s] = d;
      m_r[s] = REP;
    end else if (c) begin
      m_v[s] = 0;
      m_u[s] = 0;
    end
  endtask

  // One clock: check DUT against model, then drive and advance model.
  task automatic cyc(input bit w, input bit c, input int s,
                     input logic [7:0] a, input logic [7:0] d,
                     input bit r, input bit rs);
    @(negedge clk);
    checks++;
    if (bus.pkt_valid !== m_ph || bus.pkt_addr !== m_oa ||
        bus.pkt_data !== m_od ||
        bus.pkt_err !== (m_oa ^ m_od) ||
        bus.pkt_slot !== m_os) begin
      failures++;
      $display("FAIL cycle t=%0t got v=%b a=%h d=%h e=%h s=%h exp v=%b a=%h d=%h e=%h s=%h",
               $time, bus.pkt_valid, bus.pkt_addr, bus.pkt_data,
               bus.pkt_err, bus.pkt_slot, m_ph, m_oa, m_od,
               m_oa ^ m_od, m_os);
    end
    if (bus.pkt_valid === 1'b1 && r && !rs) begin
      sent.push_back('{bus.pkt_addr, bus.pkt_data,
                       bus.pkt_err, bus.pkt_slot});
    end
    bus.wr_en     = w;
    bus.clr_en    = c;
    bus.wr_slot   = 2'(s);
    bus.wr_addr   = a;
    bus.wr_data   = d;
    bus.pkt_ready = r;
    reset         = rs;
    model_step(w, c, s, a, d, r, rs);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 8'h00, r, 0);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 1);
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 1);
    idle(1, 0);
    sent.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.pkt_valid !== 1'b0 || bus.pkt_addr !== 8'h00 ||
        bus.pkt_data !== 8'h00 || bus.pkt_err !== 8'h00 ||
        bus.pkt_slot !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs got v=%b a=%h d=%h e=%h s=%h want 0",
               bus.pkt_valid, bus.pkt_addr, bus.pkt_data,
               bus.pkt_err, bus.pkt_slot);
    end
  endtask

  task automatic test_idle();
    do_reset();
    idle(12, 1);
    checks++;
    if (sent.size() != 6) begin
      failures++;
      $display("FAIL idle_count got %0d want 6", sent.size());
    end
    foreach (sent[i]) begin
      checks++;
      if (sent[i].a !== 8'hFF || sent[i].d !== 8'h00 ||
          sent[i].e !== 8'hFF || sent[i].s !== 3'b100) begin
        failures++;
        $display("FAIL idle_pkt got %h/%h/%h s=%h want FF/00/FF s=4",
                 sent[i].a, sent[i].d, sent[i].e, sent[i].s);
      end
    end
  endtask

  task automatic test_slot_write();
    do_reset();
    cyc(1, 0, 2, 8'h03, 8'h3F, 1, 0);
    idle(13, 1);
    checks++;
    if (sent.size() < 5) begin
      failures++;
      $display("FAIL slot2_count got %0d want >=5", sent.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (sent[i].a !== 8'h03 || sent[i].d !== 8'h3F ||
            sent[i].e !== 8'h3C || sent[i].s !== 3'd2) begin
          failures++;
          $display("FAIL slot2_pkt got %h/%h/%h s=%h want 03/3F/3C s=2",
                   sent[i].a, sent[i].d, sent[i].e, sent[i].s);
        end
      end
    end
  endtask

  task automatic test_priority();
    int j;
    do_reset();
    cyc(1, 0, 0, 8'h10, 8'h01, 1, 0);
    cyc(1, 0, 1, 8'h11, 8'h02, 1, 0);
    idle(20, 1);
    sent.delete();
    cyc(1, 0, 3, 8'h13, 8'h03, 1, 0);
    idle(15, 1);
    j = -1;
    foreach (sent[i]) begin
      if (j < 0 && sent[i].s == 3'd3) j = i;
    end
    checks++;
    if (j < 0 || j > 1 || sent.size() < j + 5) begin
      failures++;
      $display("FAIL urgent_first got idx=%0d size=%0d want idx<=1",
               j, sent.size());
    end else begin
      checks++;
      if (sent[j+1].s !== 3'd3 || sent[j+2].s == sent[j+3].s ||
          sent[j+3].s == sent[j+4].s ||
          sent[j+2].s == sent[j+4].s) begin
        failures++;
        $display("FAIL rr_order got %0d %0d %0d %0d want 3 then 0/1/3 rotation",
                 sent[j+1].s, sent[j+2].s, sent[j+3].s, sent[j+4].s);
      end
    end
  endtask

  task automatic test_stall();
    int n;
    logic [7:0] ca;
    logic [7:0] cd;
    logic [2:0] cs;
    do_reset();
    cyc(1, 0, 0, 8'h20, 8'h0A, 1, 0);
    cyc(1, 0, 1, 8'h11, 8'h22, 1, 0);
    idle(16, 1);
    n = 0;
    while (!(m_ph && m_os == 3'd1) && n < 10) begin
      idle(1, 1);
      n++;
    end
    checks++;
    if (!(m_ph && m_os == 3'd1)) begin
      failures++;
      $display("FAIL stall_wait got slot=%h want offer of slot 1", m_os);
    end else begin
      ca = m_oa;
      cd = m_od;
      cs = m_os;
      sent.delete();
      for (int i = 0; i < 10; i++) begin
        if (i == 3) cyc(1, 0, 1, 8'h55, 8'h66, 0, 0);
        else idle(1, 0);
        checks++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_addr !== ca ||
            bus.pkt_data !== cd || bus.pkt_slot !== cs) begin
          failures++;
          $display("FAIL stall_hold got v=%b %h/%h s=%h want 1 %h/%h s=%h",
                   bus.pkt_valid, bus.pkt_addr, bus.pkt_data,
                   bus.pkt_slot, ca, cd, cs);
        end
      end
      idle(12, 1);
      checks++;
      if (sent.size() < REP + 2 || sent[0].a !== 8'h11 ||
          sent[REP+1].s !== 3'd0) begin
        failures++;
        $display("FAIL stall_resend got size=%0d first=%h next_slot=%0d want 11 then slot0",
                 sent.size(), sent[0].a, sent[REP+1].s);
      end else begin
        for (int i = 1; i <= REP; i++) begin
          checks++;
          if (sent[i].a !== 8'h55 || sent[i].s !== 3'd1) begin
            failures++;
            $display("FAIL stall_new got %h s=%h want 55 s=1",
                     sent[i].a, sent[i].s);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_offer();
    int n;
    do_reset();
    cyc(1, 0, 2, 8'h44, 8'h45, 0, 0);
    n = 0;
    while (!m_ph && n < 4) begin
      idle(1, 0);
      n++;
    end
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 1);
    idle(1, 1);
    checks++;
    if (bus.pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_drop got v=%b want 0", bus.pkt_valid);
    end
    idle(1, 1);
    checks++;
    if (bus.pkt_valid !== 1'b1 || bus.pkt_slot !== 3'b100) begin
      failures++;
      $display("FAIL rst_idle got v=%b s=%h want 1 s=4",
               bus.pkt_valid, bus.pkt_slot);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1, 0, 1, 8'h31, 8'h32, 1, 0);
    idle(19, 1);
    checks++;
    if (sent.size() != 10) begin
      failures++;
      $display("FAIL b2b_rate got %0d want 10", sent.size());
    end
  endtask

  task automatic test_random();
    bit w;
    bit c;
    bit r;
    bit rs;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      w  = ($urandom_range(0, 5) == 0);
      c  = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 299) == 0);
      cyc(w, c, int'($urandom_range(0, 3)),
          8'($urandom), 8'($urandom), r, rs);
    end
    idle(1, 0);
`ifdef DCC_SCHED_COUNT_EN
    checks++;
    if (pkt_count !== 16'(m_cnt)) begin
      failures++;
      $display("FAIL pkt_count got %0d want %0d", pkt_count, m_cnt);
    end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset         = 1'b1;
    bus.wr_en     = 1'b0;
    bus.clr_en    = 1'b0;
    bus.wr_slot   = 2'd0;
    bus.wr_addr   = 8'h00;
    bus.wr_data   = 8'h00;
    bus.pkt_ready = 1'b0;
    model_step(0, 0, 0, 8'h00, 8'h00, 0, 1);
    test_reset();
    test_idle();
    test_slot_write();
    test_priority();
    test_stall();
    test_reset_mid_offer();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcc_scheduler.md
DCC_SCHEDULER -- requirements
Module: dcc_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 4, number of locomotive command slots; the only supported value is 4.
REQ-002 Parameter REPEAT, default 2, number of transmissions for a newly written command before it becomes refresh-only; range 1-15.
REQ-003 Port clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port wr_en  input  1  host writes slot wr_slot this cycle.
REQ-006 Port clr_en  input  1  host invalidates slot wr_slot this cycle.
REQ-007 Port wr_slot  input  2  target slot index.
REQ-008 Port wr_addr  input  8  DCC address byte.
REQ-009 Port wr_data  input  8  DCC instruction byte.
REQ-010 Port pkt_valid  output  1  packet offered to the DCC encoder.
REQ-011 Port pkt_ready  input  1  encoder accepts the offered packet.
REQ-012 Port pkt_addr, pkt_data, pkt_err  output  8 each  address byte, instruction byte, error byte.
REQ-013 Port pkt_slot  output  3  bit2 = idle packet; bits1:0 = source slot.

Function
REQ-014 Each slot SHALL hold valid, urgent, addr[7:0], data[7:0] and rep[3:0].
REQ-015 wr_en SHALL load addr/data, set valid=1 and urgent=1, and set rep=REPEAT.
REQ-016 clr_en SHALL clear valid and urgent; wr_en and clr_en together SHALL act as wr_en.
REQ-017 The FSM SHALL have two states: SELECT and OFFER.
REQ-018 SELECT SHALL last exactly one cycle: latch the chosen packet into the output registers and go to OFFER; pkt_valid=0 in SELECT.
REQ-019 Selection priority SHALL be: urgent slots round-robin first, then valid slots round-robin, then the idle packet.
REQ-020 Each class SHALL keep its own round-robin pointer, starting one slot after the last granted slot of that class.
REQ-021 The idle packet SHALL be addr=8'hFF, data=8'h00, pkt_slot=3'b100.
REQ-022 pkt_err SHALL equal pkt_addr XOR pkt_data.
REQ-023 In OFFER, pkt_valid=1 and all pkt_* outputs SHALL be held stable until pkt_valid and pkt_ready are both high.
REQ-024 On acceptance, the FSM SHALL return to SELECT; if the sent slot is urgent, its rep SHALL decrement and urgent SHALL clear when rep reaches 0.
REQ-025 Back-to-back throughput SHALL be one packet per 2 cycles when pkt_ready is held high.
REQ-026 A write to the slot being offered SHALL NOT alter the pkt_* outputs; the write wins and the acceptance decrement is discarded (rep=REPEAT, urgent=1).
REQ-027 A clr_en on the slot being offered SHALL let the offer complete unchanged, and the slot SHALL end invalid.

Reset
REQ-028 Reset SHALL clear all valid, urgent and rep bits and both round-robin pointers (next grant = slot 0).
REQ-029 Reset SHALL put the FSM in SELECT and drive pkt_valid=0, pkt_addr=0, pkt_data=0, pkt_err=0, pkt_slot=0.
REQ-030 Reset asserted during OFFER SHALL drop pkt_valid at the next edge and discard the offer.

Configuration
REQ-031 Macro DCC_SCHED_COUNT_EN defined SHALL add output port pkt_count[15:0].
REQ-032 pkt_count SHALL reset to 0, increment on every accepted packet and wrap from 16'hFFFF to 0.
REQ-033 With DCC_SCHED_COUNT_EN undefined, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 No writes, pkt_ready=1 -> idle packets FF/00/FF, pkt_slot=4, pkt_valid high every other cycle.
REQ-035 Write slot2 03/3F, REPEAT=2 -> two packets 03/3F/3C from slot2, then slot2 refresh alternates with nothing else valid (slot2 every offer).
REQ-036 Slots 0,1 valid non-urgent, then write slot3 -> next two offers are slot3, then refresh resumes 0,1,3 round-robin.
REQ-037 Hold pkt_ready=0 for 10 cycles during OFFER and write the offered slot -> outputs stable, then slot re-sent REPEAT times.
REQ-038 Reset mid-OFFER -> pkt_valid=0 next cycle, all slots invalid, idle packet offered after reset.
